// File: rtl/tristate_bus_ctrl_pkg.sv
// rtl/tristate_bus_ctrl_pkg.sv - shared types and width helpers for the tristate bus controller
package tristate_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    TURN  = 2'd2
  } state_e;

  localparam int DEF_WIDTH = 4;
  // Burst counter covers MAX_BURST up to 15; turnaround counter covers TURN_CYC up to 3.
  localparam int CNT_W     = 4;
  localparam int TURN_W    = 2;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tristate_bus_ctrl_if.sv
// rtl/tristate_bus_ctrl_if.sv - requester/bus bundle between the controller and its requesters
interface tristate_bus_ctrl_if
  import tristate_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = DEF_WIDTH
);
  localparam int OW = idx_w(N_REQ);

  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] req_data;
  logic [N_REQ-1:0]       req_last;
  logic [N_REQ-1:0]       gnt;
  logic [WIDTH-1:0]       a;
  logic                   en;
  logic [OW-1:0]          owner;
  logic                   busy;

  modport master (
    input  req, req_data, req_last,
    output gnt, a, en, owner, busy
  );

  modport slave (
    output req, req_data, req_last,
    input  gnt, a, en, owner, busy
  );

endinterface

// File: rtl/tristate_bus_ctrl_rr_arb.sv
// rtl/tristate_bus_ctrl_rr_arb.sv - combinational round-robin pick starting after the pointer
module tristate_rr_arb
  import tristate_pkg::*;
#(
  parameter int N_REQ = 4,
  localparam int OW   = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [OW-1:0]    ptr_i,
  output logic [OW-1:0]    winner_o,
  output logic             any_req_o
);

  logic [OW-1:0] idx;

  // Walk from farthest to nearest so the closest requester after the pointer wins last.
  always_comb begin
    winner_o  = ptr_i;
    any_req_o = 1'b0;
    idx       = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = OW'((int'(ptr_i) + k) % N_REQ);
      if (req_i[idx]) begin
        winner_o  = idx;
        any_req_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tristate_bus_ctrl.sv
// rtl/tristate_bus_ctrl.sv - round-robin burst arbiter driving registered a/en of a tristate buffer
module tristate_bus_ctrl
  import tristate_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int WIDTH     = DEF_WIDTH,
  parameter int MAX_BURST = 4,
  parameter int TURN_CYC  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  tristate_bus_ctrl_if.master  bus
);

  localparam int OW = idx_w(N_REQ);

  state_e            state_q, state_d;
  logic [OW-1:0]     owner_q, owner_d;
  logic [OW-1:0]     ptr_q, ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TURN_W-1:0] turn_q, turn_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic              en_q, en_d;

  logic [OW-1:0]     winner;
  logic              any_req;
  logic              req_own;
  logic              last_own;
  logic [WIDTH-1:0]  data_own;
  logic [N_REQ-1:0]  gnt;

  tristate_rr_arb #(.N_REQ(N_REQ)) u_arb (
    .req_i     (bus.req),
    .ptr_i     (ptr_q),
    .winner_o  (winner),
    .any_req_o (any_req)
  );

  assign req_own  = bus.req[owner_q];
  assign last_own = bus.req_last[owner_q];
  assign data_own = bus.req_data[int'(owner_q)*WIDTH +: WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= OW'(N_REQ - 1);
      cnt_q   <= '0;
      turn_q  <= '0;
      a_q     <= '0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      turn_q  <= turn_d;
      a_q     <= a_d;
      en_q    <= en_d;
    end
  end

  // a/en default to zero so an undriven bus always presents a=0.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    turn_d  = turn_q;
    a_d     = '0;
    en_d    = 1'b0;
    gnt     = '0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          owner_d = winner;
          ptr_d   = winner;
          cnt_d   = '0;
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        gnt[owner_q] = req_own;
        if (req_own) begin
          a_d   = data_own;
          en_d  = 1'b1;
          cnt_d = cnt_q + CNT_W'(1);
          if (last_own || (cnt_q == CNT_W'(MAX_BURST - 1))) begin
            state_d = TURN;
            turn_d  = '0;
          end
        end else begin
          state_d = TURN;
          turn_d  = '0;
        end
      end
      TURN: begin
        if (turn_q == TURN_W'(TURN_CYC)) begin
          state_d = IDLE;
        end else begin
          turn_d = turn_q + TURN_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.gnt   = gnt;
  assign bus.a     = a_q;
  assign bus.en    = en_q;
  assign bus.owner = owner_q;
  assign bus.busy  = (state_q != IDLE);

endmodule

// File: tb/tb_tristate_bus_ctrl.sv
// tb/tb_tristate_bus_ctrl.sv - directed bench with a transfer-level model of the tristate bus controller
module tb_tristate_bus_ctrl;
  import tristate_pkg::*;

  localparam int N  = 4;
  localparam int W  = 4;
  localparam int MB = 4;
  localparam int TC = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tristate_bus_ctrl_if #(.N_REQ(N), .WIDTH(W)) bus ();

  tristate_bus_ctrl #(.N_REQ(N), .WIDTH(W), .MAX_BURST(MB), .TURN_CYC(TC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int vec_cnt = 0;
  int err_cnt = 0;

  logic [W-1:0] wd [N][8];
  logic         wl [N][8];
  int           nw [N];
  int           wi [N];
  logic [N-1:0] gnt_smp = '0;

  logic [7:0] log_q [$];
  int         runs_q [$];

  logic         pv = 1'b0;
  logic [W-1:0] pdata = '0;
  logic [1:0]   pown = '0;
  int           cur_run = 0;
  int           low_cnt = 0;
  logic         had_burst = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Requesters: present the next queued word, advance when the previous cycle granted it.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < N; i++) begin
      if (rst_n && gnt_smp[i]) wi[i]++;
      if (wi[i] < nw[i]) begin
        bus.req[i]            = 1'b1;
        bus.req_last[i]       = wl[i][wi[i]];
        bus.req_data[i*W +: W] = wd[i][wi[i]];
      end else begin
        bus.req[i]            = 1'b0;
        bus.req_last[i]       = 1'b0;
        bus.req_data[i*W +: W] = '0;
      end
    end
  end

  // Model: a granted word must appear on a/en the following cycle; otherwise the bus is idle (a=0).
  always @(negedge clk) begin
    gnt_smp = bus.gnt;
    if (!rst_n) begin
      pv        = 1'b0;
      cur_run   = 0;
      low_cnt   = 0;
      had_burst = 1'b0;
    end else begin
      chk("gnt_onehot", 32'($countones(bus.gnt) <= 1), 32'd1);
      chk("gnt_without_req", 32'(bus.gnt & ~bus.req), 32'd0);
      chk("en", 32'(bus.en), 32'(pv));
      chk("a", 32'(bus.a), pv ? 32'(pdata) : 32'd0);
      if (bus.en) begin
        if (cur_run == 0 && had_burst) chk("turn_gap", 32'(low_cnt >= TC + 2), 32'd1);
        log_q.push_back({2'b00, pown, bus.a});
        cur_run++;
      end else begin
        if (cur_run > 0) begin
          runs_q.push_back(cur_run);
          chk("run_max", 32'(cur_run <= MB), 32'd1);
          had_burst = 1'b1;
          low_cnt   = 0;
        end
        cur_run = 0;
        low_cnt++;
      end
      pv = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (bus.gnt[i]) begin
          pv    = 1'b1;
          pdata = bus.req_data[i*W +: W];
          pown  = 2'(i);
          chk("owner_on_gnt", 32'(bus.owner), 32'(i));
        end
      end
    end
  end

  task automatic clear_all();
    log_q.delete();
    runs_q.delete();
    for (int i = 0; i < N; i++) begin
      nw[i] = 0;
      wi[i] = 0;
    end
  endtask

  task automatic load1(input int i, input int n, input logic [31:0] data, input logic [7:0] lasts);
    for (int k = 0; k < 8; k++) begin
      wd[i][k] = data[k*4 +: 4];
      wl[i][k] = lasts[k];
    end
    wi[i] = 0;
    nw[i] = n;
  endtask

  task automatic wait_idle(input string nm);
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!(bus.busy == 1'b0 && bus.req == '0 && bus.en == 1'b0) && t < 300);
    chk(nm, 32'(t < 300), 32'd1);
    @(negedge clk);
  endtask

  task automatic check_log(input string nm, input int n, input logic [63:0] exp);
    chk({nm, "_words"}, 32'(log_q.size()), 32'(n));
    for (int k = 0; k < n && k < log_q.size(); k++)
      chk({nm, "_word"}, 32'(log_q[k]), 32'(exp[k*8 +: 8]));
  endtask

  task automatic check_runs(input string nm, input int n, input logic [31:0] exp);
    chk({nm, "_bursts"}, 32'(runs_q.size()), 32'(n));
    for (int k = 0; k < n && k < runs_q.size(); k++)
      chk({nm, "_burst_len"}, 32'(runs_q[k]), 32'(exp[k*4 +: 4]));
  endtask

  initial begin
    int t;
    bus.req      = '0;
    bus.req_data = '0;
    bus.req_last = '0;
    clear_all();

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("rst_a", 32'(bus.a), 32'd0);
      chk("rst_en", 32'(bus.en), 32'd0);
      chk("rst_gnt", 32'(bus.gnt), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_owner", 32'(bus.owner), 32'd0);
    end

    // Single-word burst from requester 1: arbitrate, grant, then drive.
    clear_all();
    load1(1, 1, 32'hA, 8'h01);
    @(negedge clk);
    chk("t2_arb_gnt", 32'(bus.gnt), 32'd0);
    @(negedge clk);
    chk("t2_gnt", 32'(bus.gnt), 32'b0010);
    chk("t2_en_pre", 32'(bus.en), 32'd0);
    @(negedge clk);
    chk("t2_en", 32'(bus.en), 32'd1);
    chk("t2_a", 32'(bus.a), 32'hA);
    chk("t2_gnt_off", 32'(bus.gnt), 32'd0);
    @(negedge clk);
    chk("t2_en_off", 32'(bus.en), 32'd0);
    chk("t2_owner", 32'(bus.owner), 32'd1);
    wait_idle("t2_done");
    check_log("t2", 1, 64'h1A);
    check_runs("t2", 1, 32'h1);

    // Five words without last: cut at MAX_BURST, remainder in a second grant.
    clear_all();
    load1(2, 5, 32'h54321, 8'h00);
    wait_idle("t3_done");
    check_log("t3", 5, 64'h25_24_23_22_21);
    check_runs("t3", 2, 32'h14);

    // Asynchronous reset in the middle of a burst.
    clear_all();
    load1(2, 3, 32'h321, 8'h00);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!bus.en && t < 50);
    chk("t_rst_wait_en", 32'(t < 50), 32'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) nw[i] = 0;
    #1;
    chk("t_rst_en", 32'(bus.en), 32'd0);
    chk("t_rst_a", 32'(bus.a), 32'd0);
    chk("t_rst_busy", 32'(bus.busy), 32'd0);
    chk("t_rst_gnt", 32'(bus.gnt), 32'd0);
    chk("t_rst_owner", 32'(bus.owner), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // All four requesting: round-robin order 0,1,2,3,0.
    clear_all();
    load1(0, 2, 32'h76, 8'h03);
    load1(1, 1, 32'h9, 8'h01);
    load1(2, 1, 32'hC, 8'h01);
    load1(3, 1, 32'hE, 8'h01);
    wait_idle("t4_done");
    check_log("t4", 5, 64'h07_3E_2C_19_06);
    check_runs("t4", 5, 32'h11111);

    // Requester 3 withdraws after two words.
    clear_all();
    load1(3, 2, 32'hBA, 8'h00);
    wait_idle("t5_done");
    check_log("t5", 2, 64'h3B_3A);
    check_runs("t5", 1, 32'h2);
    chk("t5_owner", 32'(bus.owner), 32'd3);
    chk("t5_busy", 32'(bus.busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
